// File: rtl/rv_net_node.sv
// Single-hop router node for the 8-bit ready/valid control ring: delivers
// packets addressed to ADDR locally, forwards the rest, merges local traffic.
module rv_net_node #(
  parameter logic [7:0] ADDR = 8'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] neti_dat,
  input  logic       neti_valid,
  output logic       neti_ready,
  output logic [7:0] neto_dat,
  output logic       neto_valid,
  input  logic       neto_ready,
  input  logic [7:0] loci_dat,
  input  logic       loci_valid,
  output logic       loci_ready,
  output logic [7:0] loco_dat,
  output logic       loco_valid,
  input  logic       loco_ready
);

  // Handshake: a byte moves when valid && ready at posedge; valid and data
  // are held stable by the sender until that happens, on every port.

  typedef enum logic [1:0] {I_HDR, I_LEN, I_PAY} i_state_t;
  typedef enum logic [1:0] {E_IDLE, E_FWD, E_LOC} e_state_t;
  typedef enum logic [1:0] {T_HDR, T_LEN, T_PAY} t_phase_t;

  i_state_t   i_state;
  logic [7:0] i_cnt;
  logic       i_route;   // 1 = LOCAL, 0 = FWD
  e_state_t   e_state;
  t_phase_t   t_phase;
  logic [7:0] t_cnt;
  logic       last_loc;  // last contended grant went to the local source

  logic       neto_sr, loco_sr, hdr_local, cur_route, fwd_path_ok;
  logic       neti_fire, loco_push, fwd_push, loc_push, neto_push;
  logic [7:0] neto_in;
  logic       fwd_req, loc_req;

  always_comb begin
    neto_sr     = !neto_valid || neto_ready;
    loco_sr     = !loco_valid || loco_ready;
    hdr_local   = (neti_dat == ADDR);
    cur_route   = (i_state == I_HDR) ? hdr_local : i_route;
    fwd_path_ok = (e_state == E_FWD) && neto_sr;
    neti_ready  = !reset && (cur_route ? loco_sr : fwd_path_ok);
    loci_ready  = !reset && (e_state == E_LOC) && neto_sr;
    neti_fire   = neti_valid && neti_ready;
    loco_push   = neti_fire && cur_route;
    fwd_push    = neti_fire && !cur_route;
    loc_push    = loci_valid && loci_ready;
    neto_push   = fwd_push || loc_push;
    neto_in     = fwd_push ? neti_dat : loci_dat;
    fwd_req     = neti_valid && (i_state == I_HDR) && !hdr_local;
    loc_req     = loci_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_state <= I_HDR;
      i_cnt   <= 8'd0;
      i_route <= 1'b0;
    end else if (neti_fire) begin
      case (i_state)
        I_HDR: begin
          i_route <= hdr_local;
          i_state <= I_LEN;
        end
        I_LEN: begin
          i_cnt   <= neti_dat;
          i_state <= (neti_dat == 8'd0) ? I_HDR : I_PAY;
        end
        I_PAY: begin
          i_cnt <= i_cnt - 8'd1;
          if (i_cnt == 8'd1) i_state <= I_HDR;
        end
        default: i_state <= I_HDR;
      endcase
    end
  end

  // Egress arbiter with its own packet tracker, so the grant is released
  // exactly after the last byte of the granted packet enters the neto stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      e_state  <= E_IDLE;
      t_phase  <= T_HDR;
      t_cnt    <= 8'd0;
      last_loc <= 1'b1;
    end else begin
      case (e_state)
        E_IDLE: begin
          t_phase <= T_HDR;
          if (fwd_req && loc_req) begin
            e_state  <= last_loc ? E_FWD : E_LOC;
            last_loc <= !last_loc;
          end else if (fwd_req) begin
            e_state <= E_FWD;
          end else if (loc_req) begin
            e_state <= E_LOC;
          end
        end
        E_FWD, E_LOC: begin
          if (neto_push) begin
            case (t_phase)
              T_HDR: t_phase <= T_LEN;
              T_LEN: begin
                t_cnt <= neto_in;
                if (neto_in == 8'd0) e_state <= E_IDLE;
                else t_phase <= T_PAY;
              end
              T_PAY: begin
                t_cnt <= t_cnt - 8'd1;
                if (t_cnt == 8'd1) e_state <= E_IDLE;
              end
              default: t_phase <= T_HDR;
            endcase
          end
        end
        default: e_state <= E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      neto_valid <= 1'b0;
      neto_dat   <= 8'd0;
      loco_valid <= 1'b0;
      loco_dat   <= 8'd0;
    end else begin
      if (neto_push) begin
        neto_valid <= 1'b1;
        neto_dat   <= neto_in;
      end else if (neto_ready) begin
        neto_valid <= 1'b0;
      end
      if (loco_push) begin
        loco_valid <= 1'b1;
        loco_dat   <= neti_dat;
      end else if (loco_ready) begin
        loco_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_net_node.sv
// Directed bench for rv_net_node: drivers push expected bytes into per-port
// queues, negedge monitors pop and compare whatever the DUT emits.
module tb_rv_net_node;

  localparam logic [7:0] ADDR = 8'h01;
  typedef logic [7:0] bq_t[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] neti_dat = 8'd0;
  logic       neti_valid = 1'b0;
  logic       neti_ready;
  logic [7:0] neto_dat;
  logic       neto_valid;
  logic       neto_ready = 1'b1;
  logic [7:0] loci_dat = 8'd0;
  logic       loci_valid = 1'b0;
  logic       loci_ready;
  logic [7:0] loco_dat;
  logic       loco_valid;
  logic       loco_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_neto_q[$];
  logic [7:0] exp_loco_q[$];
  logic       held = 1'b0;
  logic [7:0] held_dat = 8'd0;

  rv_net_node #(.ADDR(ADDR)) dut (
    .clock(clock), .reset(reset),
    .neti_dat(neti_dat), .neti_valid(neti_valid), .neti_ready(neti_ready),
    .neto_dat(neto_dat), .neto_valid(neto_valid), .neto_ready(neto_ready),
    .loci_dat(loci_dat), .loci_valid(loci_valid), .loci_ready(loci_ready),
    .loco_dat(loco_dat), .loco_valid(loco_valid), .loco_ready(loco_ready)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic send_neti(input bq_t pkt);
    foreach (pkt[i]) begin
      int waited;
      waited = 0;
      neti_dat   = pkt[i];
      neti_valid = 1'b1;
      @(negedge clock);
      while (!neti_ready && waited < 300) begin
        waited++;
        @(negedge clock);
      end
      if (!neti_ready) begin
        checks++;
        errors++;
        $display("FAIL neti_accept_timeout: byte %0d (%0h) not accepted after %0d cycles", i, pkt[i], waited);
        break;
      end
      @(posedge clock);
      #1;
    end
    neti_valid = 1'b0;
  endtask

  task automatic send_loci(input bq_t pkt);
    foreach (pkt[i]) begin
      int waited;
      waited = 0;
      loci_dat   = pkt[i];
      loci_valid = 1'b1;
      @(negedge clock);
      while (!loci_ready && waited < 300) begin
        waited++;
        @(negedge clock);
      end
      if (!loci_ready) begin
        checks++;
        errors++;
        $display("FAIL loci_accept_timeout: byte %0d (%0h) not accepted after %0d cycles", i, pkt[i], waited);
        break;
      end
      @(posedge clock);
      #1;
    end
    loci_valid = 1'b0;
  endtask

  task automatic expect_neto(input bq_t pkt);
    foreach (pkt[i]) exp_neto_q.push_back(pkt[i]);
  endtask

  task automatic expect_loco(input bq_t pkt);
    foreach (pkt[i]) exp_loco_q.push_back(pkt[i]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_neto_q.size() != 0 || exp_loco_q.size() != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    check({name, "_neto_left"}, exp_neto_q.size(), 0);
    check({name, "_loco_left"}, exp_loco_q.size(), 0);
  endtask

  // scoreboard monitors
  always @(negedge clock) begin
    if (!reset) begin
      if (held) begin
        check("neto_hold_valid", {31'd0, neto_valid}, 32'd1);
        check("neto_hold_dat", {24'd0, neto_dat}, {24'd0, held_dat});
      end
      if (neto_valid && neto_ready) begin
        if (exp_neto_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL neto_unexpected: got byte %0h, none expected", neto_dat);
        end else begin
          check("neto_dat", {24'd0, neto_dat}, {24'd0, exp_neto_q.pop_front()});
        end
      end
      held     = neto_valid && !neto_ready;
      held_dat = neto_dat;
    end else begin
      held = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (!reset && loco_valid && loco_ready) begin
      if (exp_loco_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL loco_unexpected: got byte %0h, none expected", loco_dat);
      end else begin
        check("loco_dat", {24'd0, loco_dat}, {24'd0, exp_loco_q.pop_front()});
      end
    end
  end

  // stimulus
  initial begin
    bq_t p_loc, p_fwd, p_a, p_b, p_big, p_part, p_post;
    logic done5;

    // reset state: header matching ADDR on neti would be ready if not gated
    reset    = 1'b1;
    neti_dat = ADDR;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_neto_valid", {31'd0, neto_valid}, 32'd0);
    check("rst_loco_valid", {31'd0, loco_valid}, 32'd0);
    check("rst_neto_dat", {24'd0, neto_dat}, 32'd0);
    check("rst_loco_dat", {24'd0, loco_dat}, 32'd0);
    check("rst_neti_ready", {31'd0, neti_ready}, 32'd0);
    check("rst_loci_ready", {31'd0, loci_ready}, 32'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    neti_dat = 8'd0;
    repeat (2) @(posedge clock);
    #1;

    // local delivery
    p_loc = {8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    expect_loco(p_loc);
    fork
      send_neti(p_loc);
      begin
        @(negedge clock);
        check("t1_hdr_ready", {31'd0, neti_ready}, 32'd1);
        @(negedge clock);
        check("t1_lat_valid", {31'd0, loco_valid}, 32'd1);
        check("t1_lat_dat", {24'd0, loco_dat}, 32'h01);
      end
    join
    wait_drain("t1");

    // forward: one grant cycle, then one stage cycle
    p_fwd = {8'h05, 8'h02, 8'h11, 8'h22};
    expect_neto(p_fwd);
    fork
      send_neti(p_fwd);
      begin
        @(negedge clock);
        check("t2_grant_ready", {31'd0, neti_ready}, 32'd0);
        check("t2_grant_valid", {31'd0, neto_valid}, 32'd0);
        @(negedge clock);
        check("t2_accept_ready", {31'd0, neti_ready}, 32'd1);
        check("t2_accept_valid", {31'd0, neto_valid}, 32'd0);
        @(negedge clock);
        check("t2_lat_valid", {31'd0, neto_valid}, 32'd1);
        check("t2_lat_dat", {24'd0, neto_dat}, 32'h05);
      end
    join
    wait_drain("t2");

    // contention: FWD first, then LOC, then FWD
    p_a = {8'h09, 8'h01, 8'h33};
    p_b = {8'h07, 8'h00};
    expect_neto(p_a);
    expect_neto(p_b);
    fork
      send_neti(p_a);
      send_loci(p_b);
    join
    wait_drain("t3");

    expect_neto(p_b);
    expect_neto(p_a);
    fork
      send_neti(p_a);
      send_loci(p_b);
    join
    wait_drain("t4a");

    expect_neto(p_a);
    expect_neto(p_b);
    fork
      send_neti(p_a);
      send_loci(p_b);
    join
    wait_drain("t4b");

    // 10-byte forward packet under random downstream backpressure
    p_big = {8'h05, 8'h08, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    expect_neto(p_big);
    done5 = 1'b0;
    fork
      begin
        send_neti(p_big);
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          neto_ready = 1'($urandom_range(0, 1));
          @(posedge clock);
          #1;
        end
      end
    join
    neto_ready = 1'b1;
    wait_drain("t5");

    // reset mid-packet: D1 is stuck in loco and must be flushed
    p_part = {8'h01, 8'h04, 8'hD0, 8'hD1};
    expect_loco({8'h01, 8'h04, 8'hD0});
    send_neti(p_part);
    loco_ready = 1'b0;
    reset      = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("t6_flush_loco_valid", {31'd0, loco_valid}, 32'd0);
    check("t6_flush_neto_valid", {31'd0, neto_valid}, 32'd0);
    @(posedge clock);
    #1;
    loco_ready = 1'b1;
    p_post = {8'h01, 8'h01, 8'h5A};
    expect_loco(p_post);
    send_neti(p_post);
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_net_node.md
Name: rv_net_node

Overview:
- Single-hop router for the 8-bit ready/valid control network linking tblink_rpc_ctrl to synthesizable BFMs.
- Sits on the neti/neto ring between the controller and a BFM endpoint.
- Delivers packets addressed to ADDR to the local endpoint and forwards all other packets downstream.
- Merges the local endpoint's outgoing packets into the downstream stream, arbitrating only at packet boundaries.

Parameters:
- ADDR, 1: 8-bit node address; header byte equal to ADDR is delivered locally.

Ports:
- clock  in  1  Single clock; all logic is posedge-clocked.
- reset  in  1  Synchronous, active-high.
- neti_dat  in  8  Byte from upstream network.
- neti_valid  in  1  Upstream byte valid.
- neti_ready  out  1  Node accepts the upstream byte.
- neto_dat  out  8  Byte to downstream network.
- neto_valid  out  1  Downstream byte valid.
- neto_ready  in  1  Downstream accepts.
- loci_dat  in  8  Byte from local endpoint (outgoing packet).
- loci_valid  in  1  Local outgoing byte valid.
- loci_ready  out  1  Node accepts the local byte.
- loco_dat  out  8  Byte delivered to local endpoint.
- loco_valid  out  1  Local delivery byte valid.
- loco_ready  in  1  Local endpoint accepts.

Behaviour:
- Packet format: byte0 = destination address, byte1 = payload length N (0..255), then N payload bytes; total N+2 bytes.
- Transfer occurs when valid && ready at posedge. Valid is never withdrawn and data is held while valid && !ready on all outputs.
- Output stages: neto and loco are each a 1-entry registered pipeline stage.
  - Stage ready = !valid || downstream ready.
  - Latency is 1 cycle from input accept to output valid.
  - Sustained throughput is 1 byte/cycle.
- Reset values: neto_valid=0, loco_valid=0, neto_dat=0, loco_dat=0, neti_ready=0, loci_ready=0. All FSMs reset to their idle states; arbiter last-grant = LOC.
- Ingress FSM (neti): states I_HDR, I_LEN, I_PAY; 8-bit remaining counter; route bit {LOCAL, FWD}.
  - I_HDR: route is decoded combinationally from neti_dat (== ADDR → LOCAL). LOCAL requires loco stage ready. FWD requires egress state E_FWD and neto stage ready. On accept, latch route and go to I_LEN.
  - I_LEN: on accept, cnt = neti_dat. Go to I_HDR if neti_dat == 0, else I_PAY.
  - I_PAY: on each accept, cnt decrements. On accept with cnt == 1, go to I_HDR.
  - neti_ready in I_LEN/I_PAY = ready of the latched route's path.
- Egress arbiter (neto): states E_IDLE, E_FWD, E_LOC; owns its own header/length/counter tracker for the granted source.
  - E_IDLE: fwd_req = neti_valid && ingress in I_HDR && neti_dat != ADDR; loc_req = loci_valid.
  - Only one request: grant it.
  - Both requests: grant the source opposite to last-grant, then update last-grant.
  - Grant costs one cycle; no byte moves in E_IDLE. neti_ready (FWD route) = 0 and loci_ready = 0 in E_IDLE.
  - E_FWD/E_LOC: the granted source feeds the neto stage; the other source sees ready = 0. Return to E_IDLE in the cycle after the last byte of the packet is accepted into the stage (N=0: after the length byte).
- Local packets whose destination is ADDR are forwarded, not looped back.
- Simultaneous: a LOCAL-routed ingress packet and a loci packet proceed concurrently (independent paths); only neto is arbitrated.
- Reset mid-packet: both FSMs return to idle and both stages empty; partially transferred packets are dropped. Senders must restart from a header.

Test Plan:
- ADDR=1; neti sends {01,03,AA,BB,CC}, loco_ready=1 → loco emits the same 5 bytes on consecutive cycles, first byte 1 cycle after accept; neto_valid stays 0.
- neti sends {05,02,11,22} with neto_ready=1 → neto emits {05,02,11,22} back-to-back after the 1-cycle grant plus 1-cycle stage latency; loco_valid stays 0.
- loci {07,00} and neti {09,01,33} both valid in the same idle cycle → neto emits {09,01,33} first (last-grant reset = LOC), then {07,00}; no interleaving.
- Repeat the simultaneous request twice more → grants alternate LOC, FWD; packet order on neto is confirmed.
- neto_ready toggled randomly 50% during a 10-byte forward packet → no byte lost or duplicated; neto_dat stable while neto_valid && !neto_ready.
- reset asserted for 1 cycle after the 2nd payload byte of {01,04,...} → loco_valid=0 next cycle; a following packet {01,01,5A} is delivered correctly.
